// File: rtl/jpc_fetch_pkg.sv
// jpc_fetch_pkg: shared definitions for the jpc_fetch instruction fetch sequencer.
//   - fetch_state_e : state encoding of the fetch FSM (StFault only exists when
//                     JPC_FETCH_ALIGN_CHECK_EN is defined)
//   - JPC_INSTR_BYTES : PC increment per sequential fetch
package jpc_fetch_pkg;

    localparam int unsigned JPC_INSTR_BYTES = 4;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StReq   = 3'd1,
        StWait  = 3'd2,
`ifdef JPC_FETCH_ALIGN_CHECK_EN
        StDrop  = 3'd3,
        StFault = 3'd4
`else
        StDrop  = 3'd3
`endif
    } fetch_state_e;

endpackage

// File: rtl/jpc_fetch.sv
// jpc_fetch: instruction fetch sequencer closing the loop around jpc_pc.
// Reads the current PC, issues one instruction-memory read at a time and
// presents the returned word through a one-entry valid/ready buffer. Drives
// next_pc_O/pc_en_O of jpc_pc: +4 per completed fetch, target on redirect.
//
// Ports:
//   clk, rst                           clock, synchronous active-high reset
//   pc_I                               current PC from jpc_pc
//   next_pc_O, pc_en_O                 PC load value / load enable to jpc_pc
//   imem_req_valid_O, imem_req_ready_I read request handshake
//   imem_addr_O                        read address (always pc_I)
//   imem_rsp_valid_I, imem_rsp_data_I  read response (one per accepted request)
//   redirect_I, redirect_pc_I          branch/jump request (single-cycle pulse)
//   instr_valid_O, instr_ready_I       downstream handshake
//   instr_O, instr_pc_O                fetched word and its address
//   fault_O                            misaligned-redirect flag
//
// Configuration:
//   JPC_FETCH_ALIGN_CHECK_EN  defined: misaligned redirect loads the PC and parks
//                             the block in StFault (fault_O=1) until an aligned
//                             redirect. Undefined: redirect target is forced to
//                             word alignment and fault_O is tied 0.
module jpc_fetch
    import jpc_fetch_pkg::*;
#(
    parameter int unsigned JPC_ADDRESS_WIDTH = 32,
    parameter int unsigned JPC_INSTR_WIDTH = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [JPC_ADDRESS_WIDTH-1:0] pc_I,
    output logic [JPC_ADDRESS_WIDTH-1:0] next_pc_O,
    output logic                         pc_en_O,
    output logic                         imem_req_valid_O,
    input  logic                         imem_req_ready_I,
    output logic [JPC_ADDRESS_WIDTH-1:0] imem_addr_O,
    input  logic                         imem_rsp_valid_I,
    input  logic [JPC_INSTR_WIDTH-1:0]   imem_rsp_data_I,
    input  logic                         redirect_I,
    input  logic [JPC_ADDRESS_WIDTH-1:0] redirect_pc_I,
    output logic                         instr_valid_O,
    input  logic                         instr_ready_I,
    output logic [JPC_INSTR_WIDTH-1:0]   instr_O,
    output logic [JPC_ADDRESS_WIDTH-1:0] instr_pc_O,
    output logic                         fault_O
);

    localparam int unsigned AW = JPC_ADDRESS_WIDTH;
    localparam int unsigned IW = JPC_INSTR_WIDTH;

    fetch_state_e   state_q, state_d;
    logic [AW-1:0]  req_pc_q;
    logic [AW-1:0]  pc_plus4;
    logic [AW-1:0]  redir_tgt;
    logic           instr_valid_q;
    logic [IW-1:0]  instr_q;
    logic [AW-1:0]  instr_pc_q;
    logic           load_buf;

`ifdef JPC_FETCH_ALIGN_CHECK_EN
    logic           redir_misaligned;
    // Remembers a misaligned redirect taken while a response is still in flight,
    // so StDrop knows to park in StFault once that response is discarded.
    logic           pend_fault_q, pend_fault_d;

    assign redir_tgt        = redirect_pc_I;
    assign redir_misaligned = |redirect_pc_I[1:0];
`else
    logic           unused_redirect_lsb;

    assign redir_tgt           = {redirect_pc_I[AW-1:2], 2'b00};
    assign unused_redirect_lsb = ^redirect_pc_I[1:0];
`endif

    // Single adder: the only sequential PC source is the address just fetched.
    assign pc_plus4 = req_pc_q + AW'(JPC_INSTR_BYTES);

    always_comb begin
        state_d          = state_q;
        pc_en_O          = 1'b0;
        next_pc_O        = pc_I;
        imem_req_valid_O = 1'b0;
        load_buf         = 1'b0;
`ifdef JPC_FETCH_ALIGN_CHECK_EN
        pend_fault_d     = pend_fault_q;
`endif

        case (state_q)
            StIdle: state_d = StReq;
            StReq: begin
                // Only request when the buffer will have room for the answer.
                imem_req_valid_O = !instr_valid_q || instr_ready_I;
                if (imem_req_valid_O && imem_req_ready_I) begin
                    state_d = StWait;
                end
            end
            StWait: begin
                if (imem_rsp_valid_I) begin
                    load_buf  = 1'b1;
                    pc_en_O   = 1'b1;
                    next_pc_O = pc_plus4;
                    state_d   = StReq;
                end
            end
            StDrop: begin
                if (imem_rsp_valid_I) begin
`ifdef JPC_FETCH_ALIGN_CHECK_EN
                    state_d = pend_fault_q ? StFault : StReq;
`else
                    state_d = StReq;
`endif
                end
            end
`ifdef JPC_FETCH_ALIGN_CHECK_EN
            StFault: state_d = StFault;
`endif
            default: state_d = StIdle;
        endcase

        // Redirect overrides everything decided above.
        if (redirect_I) begin
            imem_req_valid_O = 1'b0;
            load_buf         = 1'b0;
            pc_en_O          = 1'b1;
            next_pc_O        = redir_tgt;
            if ((state_q == StWait || state_q == StDrop) && !imem_rsp_valid_I) begin
                // A response is still owed; swallow it before fetching again.
                state_d = StDrop;
`ifdef JPC_FETCH_ALIGN_CHECK_EN
                pend_fault_d = redir_misaligned;
`endif
            end else begin
`ifdef JPC_FETCH_ALIGN_CHECK_EN
                state_d = redir_misaligned ? StFault : StReq;
`else
                state_d = StReq;
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StIdle;
            req_pc_q      <= '0;
            instr_valid_q <= 1'b0;
            instr_q       <= '0;
            instr_pc_q    <= '0;
`ifdef JPC_FETCH_ALIGN_CHECK_EN
            pend_fault_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
`ifdef JPC_FETCH_ALIGN_CHECK_EN
            pend_fault_q <= pend_fault_d;
`endif
            if (imem_req_valid_O && imem_req_ready_I) begin
                req_pc_q <= pc_I;
            end
            if (redirect_I) begin
                instr_valid_q <= 1'b0;
            end else if (load_buf) begin
                instr_valid_q <= 1'b1;
                instr_q       <= imem_rsp_data_I;
                instr_pc_q    <= req_pc_q;
            end else if (instr_ready_I) begin
                instr_valid_q <= 1'b0;
            end
        end
    end

    assign imem_addr_O   = pc_I;
    assign instr_valid_O = instr_valid_q;
    assign instr_O       = instr_q;
    assign instr_pc_O    = instr_pc_q;

`ifdef JPC_FETCH_ALIGN_CHECK_EN
    assign fault_O = (state_q == StFault);
`else
    assign fault_O = 1'b0;
`endif

endmodule

// File: tb/tb_jpc_fetch.sv
// tb_jpc_fetch: bench for jpc_fetch. Contains a jpc_pc register model, a
// one-outstanding instruction memory with programmable latency, and a
// stream-level reference: delivered words form a +4 sequence from 0 that
// restarts at each redirect target, and requests follow the same rule.
module tb_jpc_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc;
    logic [31:0] next_pc_O;
    logic        pc_en_O;
    logic        imem_req_valid_O;
    logic        imem_req_ready;
    logic [31:0] imem_addr_O;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        instr_valid_O;
    logic        instr_ready;
    logic [31:0] instr_O;
    logic [31:0] instr_pc_O;
    logic        fault_O;

    always #5 clk = ~clk;

    jpc_fetch dut (
        .clk              (clk),
        .rst              (rst),
        .pc_I             (pc),
        .next_pc_O        (next_pc_O),
        .pc_en_O          (pc_en_O),
        .imem_req_valid_O (imem_req_valid_O),
        .imem_req_ready_I (imem_req_ready),
        .imem_addr_O      (imem_addr_O),
        .imem_rsp_valid_I (imem_rsp_valid),
        .imem_rsp_data_I  (imem_rsp_data),
        .redirect_I       (redirect),
        .redirect_pc_I    (redirect_pc),
        .instr_valid_O    (instr_valid_O),
        .instr_ready_I    (instr_ready),
        .instr_O          (instr_O),
        .instr_pc_O       (instr_pc_O),
        .fault_O          (fault_O)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Stimulus knobs
    int          k_lat_min = 1, k_lat_max = 1, k_rreq = 100, k_irdy = 100, k_redir = 0;
    bit          force_redir = 1'b0;
    logic [31:0] force_tgt;

    // Environment / model state
    logic [31:0] pc_nxt = 32'h0;
    bit          busy = 1'b0;
    int          cnt;
    logic [31:0] busy_addr;
    logic [31:0] exp_req_pc = 32'h0, exp_beat_pc = 32'h0;
    bit          prev_hold = 1'b0;
    logic [31:0] prev_instr, prev_ipc;
    bit          hs_req, beat;
    logic [31:0] hs_addr;
    int          cyc = 0, n_beats = 0, n_req = 0, beat_prev = 0, beat_last = 0;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return (a == 32'h0) ? 32'h0000_0013 : {a[15:0] ^ 16'hC3A5, a[17:2]};
    endfunction

    function automatic logic [31:0] exp_redir(input logic [31:0] t);
`ifdef JPC_FETCH_ALIGN_CHECK_EN
        return t;
`else
        return {t[31:2], 2'b00};
`endif
    endfunction

    function automatic bit pct(input int p);
        return int'($urandom_range(99)) < p;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic monitor();
        hs_req = 1'b0;
        beat   = 1'b0;
        if (!rst) begin
            check("addr_eq_pc", imem_addr_O, pc);
            if (!pc_en_O) check("next_pc_hold", next_pc_O, pc);
            if (redirect) begin
                check("redir_no_req", {31'b0, imem_req_valid_O}, 32'd0);
                check("redir_pc_en", {31'b0, pc_en_O}, 32'd1);
                check("redir_next_pc", next_pc_O, exp_redir(redirect_pc));
            end else if (pc_en_O) begin
                check("adv_on_rsp", {31'b0, imem_rsp_valid}, 32'd1);
                check("adv_next_pc", next_pc_O, busy_addr + 32'd4);
            end
            if (busy) check("one_outstanding", {31'b0, imem_req_valid_O}, 32'd0);
            if (prev_hold) begin
                check("hold_valid", {31'b0, instr_valid_O}, 32'd1);
                check("hold_instr", instr_O, prev_instr);
                check("hold_pc", instr_pc_O, prev_ipc);
            end
`ifndef JPC_FETCH_ALIGN_CHECK_EN
            check("fault_tied", {31'b0, fault_O}, 32'd0);
`endif
            if (instr_valid_O && instr_ready && !redirect) begin
                beat = 1'b1;
                check("beat_pc", instr_pc_O, exp_beat_pc);
                check("beat_data", instr_O, mem(exp_beat_pc));
                exp_beat_pc += 32'd4;
                n_beats++;
                beat_prev = beat_last;
                beat_last = cyc;
            end
            if (imem_rsp_valid) busy = 1'b0;
            if (imem_req_valid_O && imem_req_ready) begin
                hs_req  = 1'b1;
                hs_addr = imem_addr_O;
                check("req_addr", imem_addr_O, exp_req_pc);
                exp_req_pc += 32'd4;
                busy      = 1'b1;
                cnt       = int'($urandom_range(k_lat_max, k_lat_min));
                busy_addr = imem_addr_O;
                n_req++;
            end
            if (redirect) begin
                exp_req_pc  = exp_redir(redirect_pc);
                exp_beat_pc = exp_redir(redirect_pc);
            end
        end else begin
            exp_req_pc  = 32'h0;
            exp_beat_pc = 32'h0;
        end
        prev_hold  = !rst && instr_valid_O && !instr_ready && !redirect;
        prev_instr = instr_O;
        prev_ipc   = instr_pc_O;
        pc_nxt     = rst ? 32'h0 : (pc_en_O ? next_pc_O : pc);
    endtask

    // One clock cycle: drive at negedge, sample 1 time unit later.
    task automatic step();
        @(negedge clk);
        cyc++;
        pc             = pc_nxt;
        redirect       = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        if (rst) begin
            busy = 1'b0;
        end else if (busy) begin
            cnt--;
            if (cnt == 0) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = mem(busy_addr);
            end
        end
        imem_req_ready = pct(k_rreq);
        instr_ready    = pct(k_irdy);
        if (force_redir) begin
            redirect    = 1'b1;
            redirect_pc = force_tgt;
            force_redir = 1'b0;
        end else if (!rst && pct(k_redir)) begin
            redirect    = 1'b1;
            redirect_pc = pct(10) ? (32'hFFFF_FFF0 | ($urandom & 32'hC))
                                  : ($urandom & 32'h0000_0FFF);
`ifdef JPC_FETCH_ALIGN_CHECK_EN
            redirect_pc[1:0] = 2'b00;
`endif
        end
        #1;
        monitor();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;
    endtask

    initial begin
        int guard;
        int reqs;
        bit got;
        logic [31:0] wrap_next;
        rst = 1'b1; pc = 32'h0; imem_req_ready = 1'b0; imem_rsp_valid = 1'b0;
        imem_rsp_data = 32'h0; redirect = 1'b0; redirect_pc = 32'h0; instr_ready = 1'b0;

        // Reset state
        do_reset();
        check("rst_valid", {31'b0, instr_valid_O}, 32'd0);
        check("rst_instr", instr_O, 32'd0);
        check("rst_ipc", instr_pc_O, 32'd0);
        check("rst_pc_en", {31'b0, pc_en_O}, 32'd0);
        check("rst_req", {31'b0, imem_req_valid_O}, 32'd0);
        check("rst_fault", {31'b0, fault_O}, 32'd0);
        check("rst_next_pc", next_pc_O, pc);

        // Streaming at one instruction per two cycles
        n_beats = 0; guard = 0;
        while (n_beats < 3 && guard < 40) begin step(); guard++; end
        check("t1_beats", n_beats, 32'd3);
        check("t1_gap", beat_last - beat_prev, 32'd2);
        check("t1_pc_follows", pc, 32'd12);

        // Downstream stall holds the word and stops fetching
        k_irdy = 0;
        do_reset();
        guard = 0;
        while (!instr_valid_O && guard < 20) begin step(); guard++; end
        reqs = n_req;
        repeat (6) step();
        check("t2_instr", instr_O, 32'h13);
        check("t2_ipc", instr_pc_O, 32'h0);
        check("t2_pc", pc, 32'h4);
        check("t2_no_req", n_req - reqs, 32'd0);
        k_irdy = 100;
        guard = 0;
        do begin step(); guard++; end while (!hs_req && guard < 20);
        check("t2_resume", hs_addr, 32'h4);

        // Redirect in REQ with a buffered word, ready high in the redirect cycle
        k_irdy = 0;
        do_reset();
        guard = 0;
        while (!instr_valid_O && guard < 20) begin step(); guard++; end
        k_irdy = 100; force_tgt = 32'h100; force_redir = 1'b1;
        step();
        check("t3_no_beat", {31'b0, beat}, 32'd0);
        step();
        check("t3_dropped", {31'b0, instr_valid_O}, 32'd0);
        check("t3_pc", pc, 32'h100);
        check("t3_req", {31'b0, imem_req_valid_O}, 32'd1);
        check("t3_addr", imem_addr_O, 32'h100);

        // Redirect in WAIT with latency 3
        k_lat_min = 3; k_lat_max = 3;
        guard = 0;
        do begin step(); guard++; end while (!hs_req && guard < 20);
        force_tgt = 32'h200; force_redir = 1'b1;
        n_beats = 0; guard = 0;
        while (n_beats == 0 && guard < 40) begin step(); guard++; end
        check("t4_beat_pc", instr_pc_O, 32'h200);

        // Wrap at the top of the address space
        k_lat_min = 1; k_lat_max = 1;
        force_tgt = 32'hFFFF_FFFC; force_redir = 1'b1;
        step();
        got = 1'b0; wrap_next = 32'hDEAD_BEEF; guard = 0;
        do begin
            step(); guard++;
            if (pc_en_O && !redirect && !got) begin got = 1'b1; wrap_next = next_pc_O; end
        end while (!(hs_req && hs_addr == 32'h0) && guard < 40);
        check("t5_next_pc", wrap_next, 32'h0);
        check("t5_req_at_0", hs_addr, 32'h0);

        // Misaligned redirect
        force_tgt = 32'h102; force_redir = 1'b1;
        step();
`ifdef JPC_FETCH_ALIGN_CHECK_EN
        repeat (4) step();
        check("t6_fault_set", {31'b0, fault_O}, 32'd1);
        reqs = n_req;
        repeat (5) step();
        check("t6_no_req", n_req - reqs, 32'd0);
        force_tgt = 32'h104; force_redir = 1'b1;
        step();
        step();
        check("t6_fault_clr", {31'b0, fault_O}, 32'd0);
        guard = 0;
        while (!hs_req && guard < 20) begin step(); guard++; end
        check("t6_req_addr", hs_addr, 32'h104);
`else
        guard = 0;
        while (!hs_req && guard < 20) begin step(); guard++; end
        check("t6_fault", {31'b0, fault_O}, 32'd0);
        check("t6_req_addr", hs_addr, 32'h100);
`endif

        // Randomised traffic against the stream model
        k_lat_min = 1; k_lat_max = 4; k_rreq = 70; k_irdy = 70; k_redir = 4;
        n_beats = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(499) == 0) begin
                rst = 1'b1;
                step();
                step();
                rst = 1'b0;
            end
            step();
        end
        check("t7_progress", {31'b0, n_beats > 200}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/jpc_fetch.md
# jpc_fetch

Instruction fetch sequencer that closes the loop around `jpc_pc`. It reads the current PC, issues one instruction-memory read at a time, and presents the returned word downstream through a one-entry valid/ready buffer. It drives `next_pc_I`/`en_I` of `jpc_pc`, advancing by 4 on each fetch, loading a target on redirect, and holding on stall.

## Interface
- `JPC_ADDRESS_WIDTH`, default 32: PC/address width (`` `JPC_ADDRESS_WIDTH`` from `jpc_config.v` when defined).
- `JPC_INSTR_WIDTH`, default 32: instruction word width.
- Clocking and reset: one clock; reset is synchronous and active-high. Ports are `clk` and `rst`.
- `clk`  in  1  clock.
- `rst`  in  1  synchronous active-high reset.
- `pc_I`  in  AW  current PC from `jpc_pc.pc_O`.
- `next_pc_O`  out  AW  to `jpc_pc.next_pc_I`.
- `pc_en_O`  out  1  to `jpc_pc.en_I`; PC loads `next_pc_O` at the edge where this is 1.
- `imem_req_valid_O` / `imem_req_ready_I`  out/in  1  read request handshake.
- `imem_addr_O`  out  AW  read address (= `pc_I`).
- `imem_rsp_valid_I`  in  1  response strobe, one per accepted request, ≥1 cycle after acceptance.
- `imem_rsp_data_I`  in  IW  response word.
- `redirect_I`  in  1  branch/jump request, single-cycle pulse.
- `redirect_pc_I`  in  AW  redirect target.
- `instr_valid_O` / `instr_ready_I`  out/in  1  downstream handshake.
- `instr_O`  out  IW  fetched instruction.
- `instr_pc_O`  out  AW  address of `instr_O`.
- `fault_O`  out  1  misaligned-redirect flag (see Configuration).

## Operation
- States: IDLE, REQ, WAIT, DROP, plus FAULT with the macro.
- Reset: state IDLE. All outputs are 0: `instr_valid_O`, `instr_O`, `instr_pc_O`, `pc_en_O`, `imem_req_valid_O`, `fault_O`.
  - `next_pc_O` = `pc_I` whenever `pc_en_O`=0.
  - `imem_addr_O` = `pc_I` at all times.
- IDLE: go to REQ unconditionally next cycle.
- REQ:
  - `imem_req_valid_O` = !`redirect_I` && (!`instr_valid_O` || `instr_ready_I`).
  - Valid may drop without acceptance; the memory samples only on valid&&ready.
  - On handshake, latch `req_pc` <= `pc_I` and go to WAIT.
- WAIT, on `imem_rsp_valid_I` without redirect:
  - `instr_O` <= data, `instr_pc_O` <= `req_pc`, `instr_valid_O` <= 1.
  - Same cycle: `pc_en_O`=1, `next_pc_O`=`req_pc`+4 (mod 2^AW, so 0xFFFFFFFC wraps to 0).
  - Go to REQ.
- Buffer: `instr_valid_O` clears on `instr_ready_I`, unless it is reloaded in the same cycle.
- Redirect has priority over everything, in any state. In the cycle it is asserted:
  - `pc_en_O`=1, `next_pc_O`=`redirect_pc_I`.
  - `instr_valid_O` <= 0. Any buffered word is discarded, even if `instr_ready_I`=1 that cycle.
  - No request is issued.
- Next state after redirect:
  - From IDLE/REQ: REQ.
  - From WAIT with `imem_rsp_valid_I` that same cycle: the response is discarded, go to REQ.
  - From WAIT without a response: DROP.
  - From DROP: stay in DROP (PC is reloaded again).
- DROP: wait for the outstanding response, discard it, go to REQ. No PC update unless redirected.
- `rst` mid-WAIT/DROP: go to IDLE. A late response arriving in IDLE or REQ is ignored. The memory must not respond after `rst`.

## Timing
- Request-to-PC latency: PC advances at the edge ending the response cycle. The next request issues the following cycle with the new `pc_I`.
- Single-cycle memory with `instr_ready_I`=1: one instruction every 2 cycles (REQ, WAIT).
- Redirect at cycle N: `pc_I`=target at N+1. First request for the target issues at N+1 (from REQ) or after the DROP response.
- `instr_O`/`instr_pc_O` are held stable while `instr_valid_O`=1 and `instr_ready_I`=0.

## Configuration
- `JPC_FETCH_ALIGN_CHECK_EN`, defined:
  - A redirect with `redirect_pc_I[1:0]`≠0 still loads the PC, but the block enters FAULT and sets `fault_O`=1 (registered).
  - FAULT issues no requests.
  - FAULT is left only by an aligned redirect (clears `fault_O`, go to REQ) or by `rst`.
  - A misaligned redirect arriving in WAIT goes to DROP first, then FAULT.
- Undefined:
  - `next_pc_O` on redirect uses `{redirect_pc_I[AW-1:2],2'b00}`.
  - `fault_O` is tied 0 and the FAULT state does not exist.

## Structure
- Shared package/header `jpc_fetch_pkg`: state encoding localparams and `JPC_INSTR_BYTES`=4.
- No sub-module. State machine and output buffer are inline. The +4 adder is shared between the `next_pc_O` mux paths.

## Test plan
- Reset, then release with a 1-cycle memory returning 0x00000013 at 0, and `instr_ready_I`=1 → `instr_pc_O`=0, 4, 8 on successive valid beats, 2 cycles apart; `pc_I` follows.
- `instr_ready_I`=0 after the first word → `instr_O`=0x13 and `instr_pc_O`=0 are held, no further `imem_req_valid_O`, `pc_I`=4 stays constant; releasing ready resumes the fetch at 4.
- `redirect_I` with 0x100 in REQ → `pc_I`=0x100 next cycle, next `imem_addr_O`=0x100, buffered word dropped.
- `redirect_I` with 0x200 in WAIT (memory latency 3) → old response discarded (DROP), next request at 0x200, first delivered `instr_pc_O`=0x200.
- `pc_I`=0xFFFFFFFC fetch → `next_pc_O`=0 and the next fetch is at 0.
- With the macro, redirect to 0x102 → `fault_O`=1, no requests; redirect to 0x104 → `fault_O`=0 and fetch at 0x104. Without the macro, the same stimulus fetches at 0x100 with `fault_O`=0.
